// File: rtl/operand_capture_if.sv
// Operand-capture bus: the switch byte and raw buttons going in, and the assembled
// operand with its status going out.
interface operand_capture_if #(
  parameter int WIDTH = 16
) ();
  logic [7:0]       sw;
  logic             btn_load;
  logic             btn_clear;
  logic [WIDTH-1:0] operand;
  logic             operand_valid;
  logic             byte_ptr;
  logic             have_operand;

  modport master (
    output sw, btn_load, btn_clear,
    input  operand, operand_valid, byte_ptr, have_operand
  );

  modport slave (
    input  sw, btn_load, btn_clear,
    output operand, operand_valid, byte_ptr, have_operand
  );
endinterface

// File: rtl/operand_capture.sv
// Assembles a two-byte operand from a switch bank using two debounced load presses;
// a debounced clear press abandons a half-built operand.
module operand_capture #(
  parameter int WIDTH           = 16,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20
) (
  input  logic               clk,
  input  logic               rst,
  operand_capture_if.slave   bus
);

  localparam logic [0:0]       WAIT_LO = 1'b0;
  localparam logic [0:0]       WAIT_HI = 1'b1;
  localparam logic [CNT_W-1:0] TERM    = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Button index 0 = load, 1 = clear.
  logic [1:0]       raw;
  logic [1:0]       s1;
  logic [1:0]       s2;
  logic [1:0]       db_level;
  logic [1:0]       db_level_d;
  logic [1:0]       armed;
  logic [1:0]       sync_vld;
  logic [CNT_W-1:0] cnt [2];
  logic [1:0]       pulse;
  logic             load_pulse;
  logic             clear_pulse;

  logic [0:0]       state;
  logic [7:0]       lo_reg;
  logic [WIDTH-1:0] operand_r;
  logic             operand_valid_r;
  logic             have_operand_r;

  assign raw = {bus.btn_clear, bus.btn_load};

  // Synchronize, debounce and arm each button. A button only becomes armed once a
  // genuinely synchronized low level is seen, so a press held through reset cannot
  // produce an edge until it is released and pressed again.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1         <= '0;
      s2         <= '0;
      db_level   <= '0;
      db_level_d <= '0;
      armed      <= '0;
      sync_vld   <= '0;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      s1         <= raw;
      s2         <= s1;
      db_level_d <= db_level;
      sync_vld   <= {sync_vld[0], 1'b1};
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == db_level[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == TERM) begin
          db_level[i] <= s2[i];
          cnt[i]      <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
        if (sync_vld[1] && !s2[i] && !db_level[i]) armed[i] <= 1'b1;
      end
    end
  end

  assign pulse       = db_level & ~db_level_d & armed;
  assign load_pulse  = pulse[0];
  assign clear_pulse = pulse[1];

  // Capture FSM; clear takes priority over a coincident load.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= WAIT_LO;
      lo_reg          <= '0;
      operand_r       <= '0;
      operand_valid_r <= 1'b0;
      have_operand_r  <= 1'b0;
    end else begin
      operand_valid_r <= 1'b0;
      if (clear_pulse) begin
        state  <= WAIT_LO;
        lo_reg <= '0;
      end else if (load_pulse) begin
        if (state == WAIT_LO) begin
          lo_reg <= bus.sw;
          state  <= WAIT_HI;
        end else begin
          operand_r       <= WIDTH'({bus.sw, lo_reg});
          operand_valid_r <= 1'b1;
          have_operand_r  <= 1'b1;
          state           <= WAIT_LO;
        end
      end
    end
  end

  assign bus.operand       = operand_r;
  assign bus.operand_valid = operand_valid_r;
  assign bus.byte_ptr      = (state == WAIT_HI);
  assign bus.have_operand  = have_operand_r;

endmodule
